// File: rtl/wb_pkg.sv
// Shared types for the Wishbone master bridge: FSM encoding, size codes
// and the alignment rule applied to CPU requests.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_DONE,
        ST_FAIL
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Reserved size code counts as misaligned so it takes the error path.
    function automatic logic misaligned(input logic [1:0] size,
                                        input logic [1:0] lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lo[0];
            SZ_WORD: misaligned = |lo;
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_steer.sv
// Little-endian lane steering: byte selects and replicated write data
// for a request, and right-justified zero-extended read data from the bus.
module wb_lane_steer
    import wb_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lo,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdat,
    output logic [3:0]  sel,
    output logic [31:0] bus_wdat,
    output logic [31:0] rdata
);

    logic [31:0] shifted;

    assign shifted = bus_rdat >> {lo, 3'b000};

    always_comb begin
        sel      = 4'b1111;
        bus_wdat = wdata;
        rdata    = bus_rdat;
        case (size)
            SZ_BYTE: begin
                sel      = 4'b0001 << lo;
                bus_wdat = {4{wdata[7:0]}};
                rdata    = {24'h0, shifted[7:0]};
            end
            SZ_HALF: begin
                sel      = 4'b0011 << lo;
                bus_wdat = {2{wdata[15:0]}};
                rdata    = {16'h0, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Wishbone classic initiator: one bus cycle per CPU load/store.
// Define WBM_TIMEOUT_EN to abort bus cycles that get no ack/err in time.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic [1:0]  cpu_size_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_ready_o,
    output logic        cpu_err_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    state_t      state_q, state_n;
    logic [1:0]  size_q, lo_q;
    logic        we_q, cyc_q, ready_q, err_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q, dat_q, rdata_q;
    logic [1:0]  st_size, st_lo;
    logic [3:0]  st_sel;
    logic [31:0] st_wdat, st_rdata;
    logic        in_bus, accept, tmo_hit;

    assign in_bus  = state_q == ST_BUS;
    assign accept  = (state_q == ST_IDLE) && (state_n == ST_BUS);
    // Steering sees the live request in IDLE and the latched one in BUS.
    assign st_size = in_bus ? size_q : cpu_size_i;
    assign st_lo   = in_bus ? lo_q : cpu_addr_i[1:0];

    wb_lane_steer u_steer (
        .size     (st_size),
        .lo       (st_lo),
        .wdata    (cpu_wdata_i),
        .bus_rdat (wb_dat_i),
        .sel      (st_sel),
        .bus_wdat (st_wdat),
        .rdata    (st_rdata)
    );

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    state_n = misaligned(cpu_size_i, cpu_addr_i[1:0])
                            ? ST_FAIL : ST_BUS;
                end
            end
            ST_BUS: begin
                if (wb_err_i)     state_n = ST_FAIL;
                else if (wb_ack_i) state_n = ST_DONE;
                else if (tmo_hit) state_n = ST_FAIL;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            size_q  <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_n;
            cyc_q   <= state_n == ST_BUS;
            ready_q <= (state_n == ST_DONE) || (state_n == ST_FAIL);
            err_q   <= state_n == ST_FAIL;
            if (accept) begin
                size_q <= cpu_size_i;
                lo_q   <= cpu_addr_i[1:0];
                we_q   <= cpu_we_i;
                adr_q  <= {cpu_addr_i[31:2], 2'b00};
                sel_q  <= st_sel;
                dat_q  <= st_wdat;
            end
            if (in_bus && wb_ack_i && !wb_err_i && !we_q) begin
                rdata_q <= st_rdata;
            end
        end
    end

`ifdef WBM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] tmo_q;

    assign tmo_hit = tmo_q == TMO_LAST;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (accept) begin
            tmo_q <= '0;
        end else if (in_bus && !wb_ack_i && !wb_err_i) begin
            tmo_q <= tmo_q + CW'(1);
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^32'(TIMEOUT_CYCLES);
`endif

    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = ready_q;
    assign cpu_err_o   = err_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Bench for wb_master_bridge: directed vector table, randomized transfers
// against a byte-lane reference model, and reset/timeout corner cases.
module tb_wb_master_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cpu_req_i = 1'b0;
    logic        cpu_we_i = 1'b0;
    logic [1:0]  cpu_size_i = '0;
    logic [31:0] cpu_addr_i = '0;
    logic [31:0] cpu_wdata_i = '0;
    logic [31:0] cpu_rdata_o;
    logic        cpu_ready_o;
    logic        cpu_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    always #5 clk_i = ~clk_i;

    wb_master_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_size_i  (cpu_size_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_ready_o (cpu_ready_o),
        .cpu_err_o   (cpu_err_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] dat_i;
        int          waits;
        logic [1:0]  resp;
    } xfer_t;

    typedef struct {
        logic        bus;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        xfer_t x;
        exp_t  e;
    } vec_t;

    int          n_chk = 0;
    int          n_bad = 0;
    logic [31:0] model_rdata = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size,
                                input logic [31:0] addr,
                                input logic [31:0] wdata,
                                input logic [31:0] dat_i, input int waits,
                                input logic [1:0] resp, input logic bus,
                                input logic [3:0] sel,
                                input logic [31:0] adr,
                                input logic [31:0] dat,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.x = '{we, size, addr, wdata, dat_i, waits, resp};
        v.e = '{bus, sel, adr, dat, rdata, err};
        return v;
    endfunction

    // Byte-count view of a transfer, independent of the RTL's structure.
    function automatic exp_t model(input xfer_t x, input logic [31:0] prev);
        exp_t        e;
        int          n;
        int          lo;
        logic [31:0] rd;
        lo = int'(x.addr % 4);
        n  = (x.size == 2'd3) ? 0 : (1 << x.size);
        e.bus = (n != 0) && ((lo % (n == 0 ? 1 : n)) == 0);
        e.sel = 4'(((1 << n) - 1) << lo);
        e.adr = x.addr - 32'(lo);
        e.dat = '0;
        for (int b = 0; b < 4; b++) begin
            if (n != 0) e.dat[8*b +: 8] = x.wdata[8*(b % n) +: 8];
        end
        e.err = !e.bus || x.resp[1];
        rd = x.dat_i >> (8 * lo);
        if (n < 4 && n > 0) rd = rd & ((32'd1 << (8 * n)) - 32'd1);
        e.rdata = (e.bus && !e.err && !x.we) ? rd : prev;
        return e;
    endfunction

    task automatic run_check(input string tag, input xfer_t x,
                             input exp_t e);
        int          bus_n = 0;
        int          rdy_k = -1;
        int          exp_lat;
        logic [3:0]  sel = '0;
        logic [31:0] adr = '0;
        logic [31:0] dat = '0;
        logic [31:0] rdata = '0;
        logic        we = 1'b0;
        logic        err = 1'b0;
        logic        stb_ok = 1'b1;
        @(negedge clk_i);
        cpu_req_i   = 1'b1;
        cpu_we_i    = x.we;
        cpu_size_i  = x.size;
        cpu_addr_i  = x.addr;
        cpu_wdata_i = x.wdata;
        for (int k = 0; k < 64 && rdy_k < 0; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o) begin
                bus_n++;
                sel = wb_sel_o;
                adr = wb_adr_o;
                dat = wb_dat_o;
                we  = wb_we_o;
                if (wb_stb_o !== 1'b1) stb_ok = 1'b0;
                if (bus_n == x.waits + 1) begin
                    {wb_err_i, wb_ack_i} = x.resp;
                    wb_dat_i = x.dat_i;
                end else begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                    wb_dat_i = $urandom;
                end
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
            if (cpu_ready_o) begin
                rdy_k     = k;
                err       = cpu_err_o;
                rdata     = cpu_rdata_o;
                cpu_req_i = 1'b0;
            end
        end
        cpu_req_i = 1'b0;
        exp_lat = e.bus ? x.waits + 1 : 0;
        chk({tag, ".bus_cycles"}, 32'(bus_n), 32'(e.bus ? x.waits + 1 : 0));
        chk({tag, ".latency"}, 32'(rdy_k), 32'(exp_lat));
        if (e.bus) begin
            chk({tag, ".sel"}, {28'h0, sel}, {28'h0, e.sel});
            chk({tag, ".adr"}, adr, e.adr);
            chk({tag, ".dat_o"}, dat, e.dat);
            chk({tag, ".we"}, {31'h0, we}, {31'h0, x.we});
            chk({tag, ".stb"}, {31'h0, stb_ok}, 32'h1);
        end
        chk({tag, ".err"}, {31'h0, err}, {31'h0, e.err});
        chk({tag, ".rdata"}, rdata, e.rdata);
        @(negedge clk_i);
        chk({tag, ".pulse"}, {30'h0, cpu_ready_o, wb_cyc_o}, 32'h0);
    endtask

    vec_t table_v[$];

    initial begin
        xfer_t x;
        exp_t  e;
        int    cyc_n;
        int    rdy_seen;

        // Reset state, sampled between edges while reset is held.
        #12;
        chk("reset.ctrl", {28'h0, cpu_ready_o, cpu_err_o, wb_cyc_o, wb_stb_o},
            32'h0);
        chk("reset.rdata", cpu_rdata_o, 32'h0);
        chk("reset.wb", {28'h0, wb_sel_o} | wb_adr_o | wb_dat_o |
            {31'h0, wb_we_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        table_v.push_back(mk(1, 0, 32'h43, 32'h34, 32'h0, 2, 2'b01,
                             1, 4'b1000, 32'h40, 32'h3434_3434, 32'h0, 0));
        table_v.push_back(mk(0, 0, 32'h40, 32'h0, 32'hAABB_CCDD, 0, 2'b01,
                             1, 4'b0001, 32'h40, 32'h0, 32'hDD, 0));
        table_v.push_back(mk(0, 1, 32'h12, 32'h0, 32'h1234_5678, 1, 2'b01,
                             1, 4'b1100, 32'h10, 32'h0, 32'h1234, 0));
        table_v.push_back(mk(0, 2, 32'h13, 32'h0, 32'h0, 0, 2'b01,
                             0, 4'b0, 32'h0, 32'h0, 32'h1234, 1));
        table_v.push_back(mk(0, 2, 32'h20, 32'h0, 32'hCAFE_F00D, 0, 2'b11,
                             1, 4'b1111, 32'h20, 32'h0, 32'h1234, 1));
        table_v.push_back(mk(1, 1, 32'h06, 32'hBEEF_1234, 32'h0, 0, 2'b01,
                             1, 4'b1100, 32'h04, 32'h1234_1234, 32'h1234, 0));
        table_v.push_back(mk(0, 1, 32'h05, 32'h0, 32'h0, 0, 2'b01,
                             0, 4'b0, 32'h0, 32'h0, 32'h1234, 1));
        table_v.push_back(mk(0, 3, 32'h00, 32'h0, 32'h0, 0, 2'b01,
                             0, 4'b0, 32'h0, 32'h0, 32'h1234, 1));
        table_v.push_back(mk(0, 2, 32'h80, 32'h0, 32'h89AB_CDEF, 1, 2'b10,
                             1, 4'b1111, 32'h80, 32'h0, 32'h1234, 1));
        table_v.push_back(mk(0, 0, 32'h81, 32'h0, 32'h1122_3344, 0, 2'b01,
                             1, 4'b0010, 32'h80, 32'h0, 32'h33, 0));
        table_v.push_back(mk(0, 2, 32'h84, 32'h0, 32'hDEAD_BEEF, 0, 2'b01,
                             1, 4'b1111, 32'h84, 32'h0, 32'hDEAD_BEEF, 0));

        foreach (table_v[i]) begin
            run_check($sformatf("tbl%0d", i), table_v[i].x, table_v[i].e);
            model_rdata = table_v[i].e.rdata;
        end

        for (int i = 0; i < 40; i++) begin
            x.we    = 1'($urandom_range(0, 1));
            x.size  = ($urandom_range(0, 9) == 0) ? 2'd3
                    : 2'($urandom_range(0, 2));
            x.addr  = $urandom;
            x.wdata = $urandom;
            x.dat_i = $urandom;
            x.waits = $urandom_range(0, 2);
            x.resp  = 2'($urandom_range(1, 3));
            e = model(x, model_rdata);
            run_check($sformatf("rnd%0d", i), x, e);
            model_rdata = e.rdata;
        end

        // Responder strobes while idle must be ignored.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            wb_ack_i = 1'b1;
            wb_err_i = k[0];
            wb_dat_i = 32'hFFFF_FFFF;
            @(negedge clk_i);
            chk($sformatf("idle_ack%0d.ctrl", k),
                {29'h0, cpu_ready_o, cpu_err_o, wb_cyc_o}, 32'h0);
            chk($sformatf("idle_ack%0d.rdata", k), cpu_rdata_o, model_rdata);
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;

        // Stalled responder: no ack or err ever arrives.
        @(negedge clk_i);
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_size_i = 2'd2;
        cpu_addr_i = 32'h200;
        cyc_n = 0;
        rdy_seen = 0;
`ifdef WBM_TIMEOUT_EN
        for (int k = 0; k < 20 && rdy_seen == 0; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o) cyc_n++;
            if (cpu_ready_o) begin
                rdy_seen  = 1;
                chk("timeout.err", {31'h0, cpu_err_o}, 32'h1);
                cpu_req_i = 1'b0;
            end
        end
        chk("timeout.cyc_cycles", 32'(cyc_n), 32'd4);
        chk("timeout.ready", 32'(rdy_seen), 32'd1);
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        cpu_req_i = 1'b1;
        @(negedge clk_i);
`else
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk_i);
            if (wb_cyc_o) cyc_n++;
            if (cpu_ready_o) rdy_seen++;
        end
        chk("stall.cyc_cycles", 32'(cyc_n), 32'd1000);
        chk("stall.ready", 32'(rdy_seen), 32'd0);
`endif
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        chk("midbus.cyc_before", {31'h0, wb_cyc_o}, 32'h1);

        // Asynchronous reset between edges while the bus cycle is open.
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        chk("midbus.reset", {29'h0, wb_cyc_o, wb_stb_o, cpu_ready_o}, 32'h0);
        model_rdata = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
        x = '{1'b0, 2'd1, 32'h302, 32'h0, 32'h5566_7788, 1, 2'b01};
        e = model(x, model_rdata);
        run_check("post_reset", x, e);
        model_rdata = e.rdata;

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end

endmodule
